// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read engine: splits (addr, len) commands into credit-checked bursts and
// streams returned beats through a FWFT FIFO. Define SDRAM_BURST_BOUNDARY_EN to keep bursts aligned.
module sdram_burst_reader #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 27,
   parameter int BURST_W    = 8,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int LEN_W      = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [LEN_W-1:0]   cmd_len,
   output logic [ADDR_W-1:0]  avm_address,
   output logic [BURST_W-1:0] avm_burstcount,
   output logic               avm_read,
   input  logic               avm_waitrequest,
   input  logic [DATA_W-1:0]  avm_readdata,
   input  logic               avm_readdatavalid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_next_addr;
   logic [LEN_W-1:0]   r_remaining;
   logic [CNT_W-1:0]   r_outstanding;
   logic [CNT_W-1:0]   w_outstanding_nxt;
   logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [CNT_W-1:0]   w_credits;
   logic               r_cmd_ready;
   logic               r_avm_read;
   logic [ADDR_W-1:0]  r_avm_address;
   logic [BURST_W-1:0] r_avm_burstcount;
   logic               r_out_valid;
   logic               r_busy;
   logic               r_done;
   logic               w_cmd_acc;
   logic               w_burst_acc;
   logic               w_push;
   logic               w_pop;
   logic [ADDR_W-1:0]  w_src_addr;
   logic [LEN_W-1:0]   w_src_len;
   logic [LEN_W-1:0]   w_blen;
   logic               w_issue;
   logic               w_cmd_ready_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
`ifdef SDRAM_BURST_BOUNDARY_EN
   localparam int OFS_W = $clog2(MAX_BURST);
   logic [LEN_W-1:0]   w_room;
`endif

   // Handshakes, credit pool and next values of the occupancy counters.
   always_comb begin
      w_cmd_acc         = cmd_valid && r_cmd_ready;
      w_burst_acc       = r_avm_read && !avm_waitrequest;
      w_push            = avm_readdatavalid;
      w_pop             = r_out_valid && out_ready;
      w_credits         = CNT_W'(FIFO_DEPTH) - r_count - r_outstanding;
      w_outstanding_nxt = r_outstanding
                          + (w_burst_acc ? CNT_W'(r_avm_burstcount) : {CNT_W{1'b0}})
                          - {{(CNT_W-1){1'b0}}, avm_readdatavalid};
      w_count_nxt       = r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
   end

   // Burst sizing; in IDLE the first burst is sized straight from the incoming command.
   always_comb begin
      w_src_addr = (r_state == S_IDLE) ? cmd_addr : r_next_addr;
      w_src_len  = (r_state == S_IDLE) ? cmd_len  : r_remaining;
      w_blen     = (w_src_len < LEN_W'(MAX_BURST)) ? w_src_len : LEN_W'(MAX_BURST);
`ifdef SDRAM_BURST_BOUNDARY_EN
      w_room     = LEN_W'(MAX_BURST) - LEN_W'(w_src_addr[OFS_W-1:0]);
      w_blen     = (w_room < w_blen) ? w_room : w_blen;
`endif
      if (r_state == S_IDLE) begin
         w_issue = w_cmd_acc && (cmd_len != {LEN_W{1'b0}})
                   && (w_credits >= CNT_W'(w_blen));
      end else begin
         w_issue = (r_state == S_ISSUE) && !r_avm_read && (r_remaining != {LEN_W{1'b0}})
                   && (w_credits >= CNT_W'(w_blen));
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_acc) begin
               w_state_nxt = (cmd_len == {LEN_W{1'b0}}) ? S_DONE : S_ISSUE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (!r_avm_read && (r_remaining == {LEN_W{1'b0}})) begin
               w_state_nxt = (w_outstanding_nxt == {CNT_W{1'b0}}) ? S_DONE : S_DRAIN;
            end else begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_DRAIN: begin
            w_state_nxt = (w_outstanding_nxt == {CNT_W{1'b0}}) ? S_DONE : S_DRAIN;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they register in step with it.
   always_comb begin
      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_done_nxt      = (w_state_nxt == S_DONE);
   end

   // State and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Request channel, command progress and FIFO bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_avm_read       <= 1'b0;
         r_avm_address    <= {ADDR_W{1'b0}};
         r_avm_burstcount <= {BURST_W{1'b0}};
         r_next_addr      <= {ADDR_W{1'b0}};
         r_remaining      <= {LEN_W{1'b0}};
         r_outstanding    <= {CNT_W{1'b0}};
         r_count          <= {CNT_W{1'b0}};
         r_wr_ptr         <= {PTR_W{1'b0}};
         r_rd_ptr         <= {PTR_W{1'b0}};
         r_out_valid      <= 1'b0;
      end else begin
         if (w_issue) begin
            r_avm_read       <= 1'b1;
            r_avm_address    <= w_src_addr;
            r_avm_burstcount <= BURST_W'(w_blen);
         end else if (w_burst_acc) begin
            r_avm_read <= 1'b0;
         end
         if (w_cmd_acc) begin
            r_next_addr <= cmd_addr;
            r_remaining <= cmd_len;
         end else if (w_burst_acc) begin
            r_next_addr <= r_next_addr + ADDR_W'(r_avm_burstcount);
            r_remaining <= r_remaining - LEN_W'(r_avm_burstcount);
         end
         r_outstanding <= w_outstanding_nxt;
         r_count       <= w_count_nxt;
         r_out_valid   <= (w_count_nxt != {CNT_W{1'b0}});
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // FIFO storage; never read past the occupancy count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= avm_readdata;
      end
   end

   assign cmd_ready      = r_cmd_ready;
   assign avm_read       = r_avm_read;
   assign avm_address    = r_avm_address;
   assign avm_burstcount = r_avm_burstcount;
   assign out_valid      = r_out_valid;
   assign out_data       = r_mem[r_rd_ptr];
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
